serial_word_receiver: RTL and testbench



---
 rtl/serial_word_receiver.sv | 249 ++++++++++++++++++++++++
 tb/tb_serial_word_receiver.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_receiver.sv
// serial_word_receiver
// Reassembles MSB-first serial frames from the 4-bit serializer stage into
// parallel words. Completed words are buffered in a small FIFO that the
// consumer drains through a valid/ready handshake.
// Optional feature: define PARITY_CHECK_EN to expect one even-parity bit
// after the data bits. Words whose parity does not match are dropped.

module serial_word_receiver #(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             input_clock1_clk_1,
  input  logic             input_push_button1_reset_2,
  input  logic             input_serial_data_3,
  input  logic             input_load_shift_4,
  input  logic             input_ready_5,
  output logic [WIDTH-1:0] output_word_6,
  output logic             output_valid_7,
  output logic             output_overrun_8,
  output logic             output_frame_err_9,
  output logic             output_parity_err_10
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Short local names for the ports.
  logic clk;
  logic rst;
  logic ser_bit;
  logic load;
  logic ready;

  assign clk     = input_clock1_clk_1;
  assign rst     = input_push_button1_reset_2;
  assign ser_bit = input_serial_data_3;
  assign load    = input_load_shift_4;
  assign ready   = input_ready_5;

  // ---------------------------------------------------------------------------
  // Frame assembly state
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             frame_err_q, frame_err_d;
  logic             push;
  logic [WIDTH-1:0] push_word;
`ifdef PARITY_CHECK_EN
  logic             parity_err_q, parity_err_d;
`endif

  // Frame FSM: collect the bits, detect restarts, and request the FIFO push.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    push_word   = shift_q;
`ifdef PARITY_CHECK_EN
    parity_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      ST_SHIFT: begin
        if (load) begin
          // A restart with no bits collected yet is a held load strobe, so
          // it is not reported as a framing error.
          frame_err_d = (cnt_q != '0);
          cnt_d       = '0;
          shift_d     = '0;
        end else begin
          shift_d = {shift_q[WIDTH-2:0], ser_bit};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
            state_d = ST_PARITY;
`else
            push      = 1'b1;
            push_word = {shift_q[WIDTH-2:0], ser_bit};
            state_d   = ST_DONE;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      ST_PARITY: begin
        if (load) begin
          frame_err_d = 1'b1;
          state_d     = ST_SHIFT;
          cnt_d       = '0;
          shift_d     = '0;
        end else begin
          // Even parity: the data bits and the parity bit together hold an
          // even number of ones.
          if (((^shift_q) ^ ser_bit) == 1'b0) begin
            push = 1'b1;
          end else begin
            parity_err_d = 1'b1;
          end
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (load) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        shift_d = '0;
      end
    endcase
  end

  // Frame FSM registers. Reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef PARITY_CHECK_EN
  // Parity error pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Completed-word FIFO
  // Handshake: output_valid_7 is high whenever the FIFO holds a word, and
  // output_word_6 is that head word. A word transfers on every rising edge
  // where valid and input_ready_5 are both high. The head stays stable until
  // it transfers. valid never depends on ready in the same cycle.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             overrun_q, overrun_d;
  logic             valid;
  logic             full;
  logic             pop;
  logic             push_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid = (occ_q != '0);
  assign full  = (occ_q == FULL_OCC);
  assign pop   = valid & ready;
  // When the FIFO is full, a push is still accepted if a pop happens on the
  // same edge. The slot being freed is the one that is written.
  assign push_ok = push & (~full | pop);

  // FIFO next-state logic: pointer and occupancy updates, plus the sticky overrun flag.
  always_comb begin
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    occ_d     = occ_q;
    overrun_d = overrun_q | (push & full & ~pop);
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push_ok, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // FIFO registers. Storage is cleared so the word output reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      occ_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      occ_q     <= occ_d;
      overrun_q <= overrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign output_word_6      = mem_q[rd_ptr_q];
  assign output_valid_7     = valid;
  assign output_overrun_8   = overrun_q;
  assign output_frame_err_9 = frame_err_q;
`ifdef PARITY_CHECK_EN
  assign output_parity_err_10 = parity_err_q;
`else
  assign output_parity_err_10 = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Testbench for serial_word_receiver. It runs directed scenarios first and
// then a randomized stream. A frame-level reference model predicts every
// output after each clock edge.
// Build with PARITY_CHECK_EN defined to exercise the parity variant.

module tb_serial_word_receiver;

  localparam int W = 4;
  localparam int D = 2;
`ifdef PARITY_CHECK_EN
  localparam int FRAME_LEN = W + 1;
`else
  localparam int FRAME_LEN = W;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0;
  logic sdata = 1'b0;
  logic ready = 1'b0;
  logic [W-1:0] word;
  logic valid, overrun, ferr, perr;

  always #5 clk = ~clk;

  serial_word_receiver #(.WIDTH(W), .FIFO_DEPTH(D)) dut (
    .input_clock1_clk_1         (clk),
    .input_push_button1_reset_2 (rst),
    .input_serial_data_3        (sdata),
    .input_load_shift_4         (load),
    .input_ready_5              (ready),
    .output_word_6              (word),
    .output_valid_7             (valid),
    .output_overrun_8           (overrun),
    .output_frame_err_9         (ferr),
    .output_parity_err_10       (perr)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [W-1:0] exp_q[$];   // words the consumer should see, in order
  int           m_bits[$];  // bits sampled so far in the current frame
  bit           m_active;   // a frame is being collected
  bit           m_overrun;
  bit           exp_ferr;
  bit           exp_perr;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive the inputs, advance the model through the edge,
  // then compare every output against the model.
  task automatic step(input logic ld, input logic bt, input logic rd);
    bit           do_pop;
    bit           have_word;
    bit           full_before;
    int           acc;
    int           ones;
    logic [W-1:0] w;
    load      = ld;
    sdata     = bt;
    ready     = rd;
    exp_ferr  = 0;
    exp_perr  = 0;
    have_word = 0;
    w         = '0;
    if (rst) begin
      exp_q.delete();
      m_bits.delete();
      m_active  = 0;
      m_overrun = 0;
    end else begin
      do_pop = rd && (exp_q.size() > 0);
      if (ld) begin
        exp_ferr = m_active && (m_bits.size() > 0);
        m_active = 1;
        m_bits.delete();
      end else if (m_active) begin
        m_bits.push_back(int'(bt));
        if (m_bits.size() == FRAME_LEN) begin
          acc  = 0;
          ones = 0;
          for (int i = 0; i < W; i++) acc = acc * 2 + m_bits[i];
          for (int i = 0; i < FRAME_LEN; i++) ones += m_bits[i];
          w = W'(acc);
`ifdef PARITY_CHECK_EN
          if (ones % 2 != 0) exp_perr = 1;
          else have_word = 1;
`else
          have_word = 1;
`endif
          m_active = 0;
          m_bits.delete();
        end
      end
      full_before = (exp_q.size() == D);
      if (do_pop) void'(exp_q.pop_front());
      if (have_word) begin
        if (!full_before || do_pop) exp_q.push_back(w);
        else m_overrun = 1;
      end
    end
    @(posedge clk);
    #1;
    check("valid", 32'(valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) check("word", 32'(word), 32'(exp_q[0]));
    if (rst) check("word_reset", 32'(word), 32'h0);
    check("overrun", 32'(overrun), 32'(m_overrun));
    check("frame_err", 32'(ferr), 32'(exp_ferr));
    check("parity_err", 32'(perr), 32'(exp_perr));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
  endtask

  // Load edge, data bits MSB first, then (optionally) an even parity bit.
  // rdy applies to every edge except the last, which uses rdy_last.
  task automatic send_frame(input logic [W-1:0] v, input logic rdy, input logic rdy_last);
    step(1, 0, rdy);
`ifdef PARITY_CHECK_EN
    for (int i = W - 1; i >= 0; i--) step(0, v[i], rdy);
    step(0, ^v, rdy_last);
`else
    for (int i = W - 1; i >= 0; i--) step(0, v[i], (i == 0) ? rdy_last : rdy);
`endif
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [3:0] bits6;
    logic ld, bt, rd;

    // Reset state
    rst = 1'b1;
    step(0, 0, 0);
    step(1, 1, 1);
    rst = 1'b0;
    check("reset_valid", 32'(valid), 32'h0);

    // Basic frame 1011, held while not ready
    send_frame(4'b1011, 0, 0);
    check("basic_valid", 32'(valid), 32'h1);
    check("basic_word", 32'(word), 32'hB);
    for (int i = 0; i < 5; i++) step(0, 1'($urandom_range(0, 1)), 0);
    check("basic_hold", 32'(word), 32'hB);
    step(0, 0, 1);
    check("basic_popped", 32'(valid), 32'h0);

    // Overrun
    do_reset();
    send_frame(4'h3, 0, 0);
    send_frame(4'h5, 0, 0);
    send_frame(4'h9, 0, 0);
    check("ovr_flag", 32'(overrun), 32'h1);
    check("ovr_head", 32'(word), 32'h3);
    step(0, 0, 1);
    check("ovr_second", 32'(word), 32'h5);
    step(0, 0, 1);
    step(0, 0, 0);
    check("ovr_empty", 32'(valid), 32'h0);
    check("ovr_sticky", 32'(overrun), 32'h1);

    // Framing error: restart after two bits
    do_reset();
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    check("frm_pulse", 32'(ferr), 32'h1);
    bits6 = 4'b0110;
    for (int i = 3; i >= 0; i--) step(0, bits6[i], 0);
    check("frm_word", 32'(word), 32'h6);
    step(0, 0, 1);
    check("frm_single", 32'(valid), 32'h0);

    // Simultaneous push and pop while full
    do_reset();
    send_frame(4'h1, 0, 0);
    send_frame(4'h2, 0, 0);
    send_frame(4'hC, 0, 1);
    check("sim_head", 32'(word), 32'h2);
    check("sim_no_ovr", 32'(overrun), 32'h0);
    step(0, 0, 1);
    check("sim_next", 32'(word), 32'hC);
    step(0, 0, 1);

    // Reset in the middle of a frame
    do_reset();
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    rst = 1'b1;
    step(0, 1, 0);
    rst = 1'b0;
    check("rmf_valid", 32'(valid), 32'h0);
    send_frame(4'h3, 0, 0);
    check("rmf_word", 32'(word), 32'h3);
    step(0, 0, 1);
    check("rmf_single", 32'(valid), 32'h0);

    // Held load strobe: one frame_err pulse only
    send_frame(4'hA, 1, 1);
    step(1, 0, 1);
    step(0, 1, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    step(0, 0, 1);

`ifdef PARITY_CHECK_EN
    // Good and bad parity
    do_reset();
    send_frame(4'hB, 0, 0);
    check("par_good", 32'(word), 32'hB);
    step(0, 0, 1);
    step(1, 0, 0);
    for (int i = 3; i >= 0; i--) step(0, bits6[i] ^ 1'b1 ^ bits6[i] ^ ((4'hB >> i) & 1'b1) ^ 1'b1, 0);
    step(0, 0, 0);
    check("par_err", 32'(perr), 32'h1);
    check("par_drop", 32'(valid), 32'h0);
`endif

    // Sustained throughput with ready=1: never overruns
    do_reset();
    for (int f = 0; f < 12; f++) send_frame(W'($urandom_range(0, (1 << W) - 1)), 1, 1);
    check("thru_no_ovr", 32'(overrun), 32'h0);

    // Random stream
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      ld  = ($urandom_range(0, 6) == 0);
      bt  = 1'($urandom_range(0, 1));
      rd  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 149) == 0);
      step(ld, bt, rd);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
